mem_stage: RTL

- Pipeline stage directly downstream of the execute stage.
- Consumes the ALU result (the effective address, or the pass-through value) plus store data and control, and performs word loads/stores on the data-memory port using a req/ack handshake.
- Produces registered writeback data, and stalls upstream while a memory access is outstanding.
- Detects misaligned accesses and ack timeouts.

---
 rtl/musa_pkg.sv | 29 ++
 rtl/mem_stage_if.sv | 24 ++
 rtl/mem_access_fsm.sv | 70 +++++++
 rtl/mem_stage.sv | 125 ++++++++++++
 4 files changed

// File: rtl/musa_pkg.sv
// Shared definitions for the memory stage: widths, FSM encoding, holding-register
// payload and the word-alignment helper.
package musa_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    // Low address bits of a word-aligned access
    localparam logic [1:0] ALIGN_MASK = 2'b00;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

    // Operation captured when an aligned memory access is accepted
    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic              we;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
    } mem_hold_t;

    function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] == ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port.
//   master (memory stage): drives mem_req, mem_we, mem_addr, mem_wdata
//   slave  (memory)      : drives mem_rdata, mem_ack (one-cycle completion pulse)
interface mem_stage_if;
    import musa_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_access_fsm.sv
// Access sequencer for the memory stage: IDLE/ACCESS state register, ack timeout
// counter and completion decode.
//   clk, reset     : clock, async active-low reset
//   start          : accept an aligned memory op (only honoured in IDLE)
//   mem_ack        : completion pulse from memory
//   state          : registered FSM state
//   ack_done_c     : access completes with an ack at the coming edge
//   timeout_c      : access aborts on timeout at the coming edge
module mem_access_fsm
    import musa_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mem_ack,
    output mem_state_e state,
    output logic       ack_done_c,
    output logic       timeout_c
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and timeout counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; an ack on the final timeout cycle still completes normally
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_done_c = 1'b0;
        timeout_c  = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (start) begin
                    state_d = MEM_ACCESS;
                    cnt_d   = '0;
                end
            end
            MEM_ACCESS: begin
                if (mem_ack) begin
                    ack_done_c = 1'b1;
                    state_d    = MEM_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_c = 1'b1;
                    state_d   = MEM_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through, performs word loads/stores
// over a req/ack port, stalls EX while an access is outstanding and flags
// misaligned accesses and ack timeouts.
//   clk, reset            : clock, async active-low reset
//   ex_*                  : instruction from EX (ignored while stall is high)
//   stall                 : access outstanding, EX must hold
//   mem                   : data-memory port (master side)
//   wb_*                  : registered writeback, wb_valid pulses one cycle
//   exc_misaligned/bus_err: registered one-cycle exception pulses
module mem_stage
    import musa_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [WORD_W-1:0] ex_result,
    input  logic [WORD_W-1:0] ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_reg_write,
    output logic              stall,
    mem_stage_if.master       mem,
    output logic              wb_valid,
    output logic [WORD_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_reg_write,
    output logic              exc_misaligned,
    output logic              exc_bus_error
);

    mem_state_e state;
    mem_hold_t  hold_q;
    logic       ack_done_c;
    logic       timeout_c;
    logic       accept_c;
    logic       mem_op_c;
    logic       start_c;
    logic       misalign_c;
    logic       alu_c;

    // Decode of the incoming instruction; only looked at in IDLE
    assign accept_c   = (state == MEM_IDLE) && ex_valid;
    assign mem_op_c   = ex_mem_read || ex_mem_write;
    assign start_c    = accept_c && mem_op_c && is_aligned(ex_result);
    assign misalign_c = accept_c && mem_op_c && !is_aligned(ex_result);
    assign alu_c      = accept_c && !mem_op_c;

    mem_access_fsm #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .start      (start_c),
        .mem_ack    (mem.mem_ack),
        .state      (state),
        .ack_done_c (ack_done_c),
        .timeout_c  (timeout_c)
    );

    // Holding registers keep the bus fields stable for the whole access;
    // a simultaneous read+write is treated as a read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else if (start_c) begin
            hold_q <= '{addr:      ex_result,
                        wdata:     ex_store_data,
                        we:        ex_mem_write && !ex_mem_read,
                        rd:        ex_rd,
                        reg_write: ex_reg_write};
        end
    end

    // Request and stall both follow the state register, so reset drops them at once
    assign stall         = (state == MEM_ACCESS);
    assign mem.mem_req   = (state == MEM_ACCESS);
    assign mem.mem_we    = hold_q.we;
    assign mem.mem_addr  = hold_q.addr;
    assign mem.mem_wdata = hold_q.wdata;

    // Writeback and exception registers; pulses default low, fields hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid       <= 1'b0;
            wb_data        <= '0;
            wb_rd          <= '0;
            wb_reg_write   <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_bus_error  <= 1'b0;
        end else begin
            wb_valid       <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_bus_error  <= 1'b0;
            if (alu_c) begin
                wb_valid     <= 1'b1;
                wb_data      <= ex_result;
                wb_rd        <= ex_rd;
                wb_reg_write <= ex_reg_write;
            end else if (misalign_c) begin
                wb_valid       <= 1'b1;
                wb_rd          <= ex_rd;
                wb_reg_write   <= 1'b0;
                exc_misaligned <= 1'b1;
            end else if (ack_done_c) begin
                wb_valid <= 1'b1;
                wb_rd    <= hold_q.rd;
                if (hold_q.we) begin
                    wb_reg_write <= 1'b0;
                end else begin
                    wb_data      <= mem.mem_rdata;
                    wb_reg_write <= hold_q.reg_write;
                end
            end else if (timeout_c) begin
                wb_valid      <= 1'b1;
                wb_rd         <= hold_q.rd;
                wb_reg_write  <= 1'b0;
                exc_bus_error <= 1'b1;
            end
        end
    end

endmodule
